vga_config_queue: RTL
=====================

# vga_config_queue

Buffers register-write requests from the host/controller side and delivers them one at a time to the VGA controller's configuration port (C_valid/C_addr/C_data/C_rdy). It sits directly upstream of VGA_Control. It lets the host post a burst of timing-register updates without stalling, while VGA_Control accepts them only when C_rdy allows. Storage is a small FIFO followed by a registered output slot that holds each request stable until the controller accepts it.

## Interface
- CONFIG_WIDTH, 4: width of both the address and data fields; the value comes from the shared VGA width parameters.
- DEPTH, 4: total request capacity, counting FIFO entries plus the output slot. Must be a power of two and at least 2.
- TIMEOUT, 255: cycles C_valid may wait for C_rdy before the request is dropped. Used only with the timeout feature.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- H_wr_en  in  1  host write strobe; one request is pushed per cycle while high.
- H_addr  in  CONFIG_WIDTH  target register address.
- H_data  in  CONFIG_WIDTH  register value.
- H_full  out  1  queue holds DEPTH requests; writes are ignored.
- H_count  out  $clog2(DEPTH)+1  requests held, including the output slot.
- C_valid  out  1  request presented to VGA_Control.
- C_addr  out  CONFIG_WIDTH  presented address.
- C_data  out  CONFIG_WIDTH  presented data.
- C_rdy  in  1  VGA_Control accepts the presented request.
- Busy  out  1  high when H_count != 0.
- Err  out  1  one-cycle pulse when a request is dropped on timeout. Tied to 0 when the timeout feature is compiled out.

## Operation
- Accept rule:
  - A write is accepted when H_wr_en=1 and H_full=0.
  - A write while H_full=1 is ignored. No state changes and no error is flagged.
  - A write is ignored when H_full=1 even if a C handshake completes in the same cycle.
- Transfer: a transfer completes on a rising edge where C_valid=1 and C_rdy=1.
- Output slot FSM:
  - IDLE (C_valid=0):
    - Loads the FIFO head when the FIFO is non-empty and goes to PRESENT.
    - If the FIFO is empty and H_wr_en is accepted, it loads the host request directly (bypass) and goes to PRESENT.
  - PRESENT (C_valid=1):
    - C_addr and C_data are held stable until the transfer.
    - On transfer, it reloads from the FIFO head if one exists and stays in PRESENT, giving back-to-back transfers with no bubble. Otherwise it goes to IDLE.
    - Bypass reload is allowed when the FIFO is empty and a write is accepted in the same cycle.
- Ordering: strict FIFO order, with no reordering or merging of duplicate addresses.
- Count: H_count increments by 1 on an accepted write and decrements by 1 on a transfer. When both happen in the same cycle it is unchanged.
- Pointers: read and write pointers wrap modulo (DEPTH-1), the FIFO storage excluding the slot.

## Timing
- Reset values:
  - C_valid=0, C_addr=0, C_data=0, H_full=0, H_count=0, Busy=0, Err=0.
  - Pointers are cleared.
- Reset asserted mid-operation discards all entries. C_valid falls asynchronously with rst_n.
- Latency: with an empty queue, a write accepted at edge n gives C_valid=1 after edge n, so it is visible in cycle n+1.
- Throughput: one transfer per cycle while the queue is non-empty and C_rdy=1.
- H_full, H_count and Busy are registered and reflect state after each edge.
- C_valid never drops without a transfer, except on reset or timeout.

## Configuration
- Macro: VGA_CFG_TIMEOUT_EN.
- Defined:
  - A wait counter runs in PRESENT and clears on every transfer or reload.
  - When the counter reaches TIMEOUT with C_rdy still 0, the request is dropped. Err pulses for one cycle and C_valid is 0 for that cycle.
  - The next entry, if present, is loaded on the following edge.
  - H_count decrements when a request is dropped.
- Undefined: no counter is built, Err=0 constantly, and the queue waits for C_rdy indefinitely.

## Structure
- Shared include holds CONFIG_WIDTH alongside the existing VGA width parameters.
- Shared include also holds the FSM state encodings IDLE=1'b0 and PRESENT=1'b1.
- Sub-module vga_cfg_fifo contains the storage array, pointers and empty/full flags.
- The top level holds the output slot FSM, count logic, bypass and timeout logic.

## Test plan
- Single write: addr=4'b1011, data=4'b0010 into an empty queue with C_rdy=1. C_valid is high for exactly one cycle, starting one cycle after the write, with addr=1011 and data=0010. Busy then returns to 0.
- Burst with back-pressure: write four requests A0..A3 on consecutive cycles with C_rdy=0. H_full=1 and H_count=4. A fifth write is ignored. Then raise C_rdy=1: A0..A3 appear on consecutive cycles in order, the fifth request never appears, and H_count steps 4→0.
- Stall stability: hold C_rdy=0 for 20 cycles with C_valid=1. C_addr and C_data must not change. Pulse C_rdy: the next entry is presented on the following cycle.
- Simultaneous push/pop at H_count=2: H_count stays 2 and order is preserved.
- Reset mid-burst: drop rst_n with 3 requests queued. C_valid goes to 0 immediately and H_count=0. After release, no stale request is ever presented.
- Timeout (VGA_CFG_TIMEOUT_EN, TIMEOUT=8): hold C_rdy=0 with 2 requests queued. After 8 cycles Err pulses once, the first request is dropped, and the second request is presented with H_count=1.

Source files
------------

// File: rtl/vga_config_queue_pkg.sv
// Shared VGA configuration parameters and output-slot state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_config_queue_pkg;

    // Width of both the address and data fields of a configuration request.
    localparam int CONFIG_WIDTH = 4;

    // Output slot states: IDLE means nothing is presented, PRESENT means C_valid is high.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } slot_state_e;

endpackage

// File: rtl/vga_cfg_fifo.sv
// Request storage ahead of the output slot: circular array with wrapping pointers and an occupancy count.
// Latency: a pushed entry is visible at head_dat after the push edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
module vga_cfg_fifo
    import vga_config_queue_pkg::*;
#(
    parameter int WIDTH   = 2 * CONFIG_WIDTH,
    parameter int ENTRIES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);

    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW = $clog2(ENTRIES + 1);

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [WIDTH-1:0] mem_d [ENTRIES];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    // The array size need not be a power of two, so pointers wrap explicitly at ENTRIES-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(ENTRIES));
    assign head_dat = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_config_queue.sv
// Host-to-VGA_Control config request queue: FIFO plus a registered output slot; optional drop-on-timeout (VGA_CFG_TIMEOUT_EN).
// Latency: a write into an empty queue is presented on C_valid the cycle after it is accepted; back-to-back transfers with no bubble.
// Backpressure: C_valid/C_addr/C_data hold until C_rdy; when DEPTH requests are held H_full rises and further writes are ignored.
module vga_config_queue
    import vga_config_queue_pkg::*;
#(
    parameter int CONFIG_WIDTH = vga_config_queue_pkg::CONFIG_WIDTH,
    parameter int DEPTH        = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       H_wr_en,
    input  logic [CONFIG_WIDTH-1:0]    H_addr,
    input  logic [CONFIG_WIDTH-1:0]    H_data,
    output logic                       H_full,
    output logic [$clog2(DEPTH):0]     H_count,
    output logic                       C_valid,
    output logic [CONFIG_WIDTH-1:0]    C_addr,
    output logic [CONFIG_WIDTH-1:0]    C_data,
    input  logic                       C_rdy,
    output logic                       Busy,
    output logic                       Err
);

    localparam int NW = $clog2(DEPTH) + 1;
    localparam int DW = 2 * CONFIG_WIDTH;

    slot_state_e             state_q, state_d;
    logic [CONFIG_WIDTH-1:0] addr_q, addr_d;
    logic [CONFIG_WIDTH-1:0] data_q, data_d;
    logic [NW-1:0]           count_q, count_d;
    logic                    full_q, busy_q;
    logic                    accept, xfer, drop, slot_free;
    logic                    fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [DW-1:0]           fifo_head;

`ifdef VGA_CFG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;
`endif

    // The slot counts toward DEPTH, so the FIFO only needs DEPTH-1 entries.
    vga_cfg_fifo #(
        .WIDTH   (DW),
        .ENTRIES (DEPTH - 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat ({H_addr, H_data}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Slot reload (FIFO head first, else bypass the host write), FIFO push, count and timeout next-state.
    always_comb begin
        accept = H_wr_en && !full_q;
        xfer   = (state_q == PRESENT) && C_rdy;
        drop   = 1'b0;
`ifdef VGA_CFG_TIMEOUT_EN
        err_d      = 1'b0;
        wait_cnt_d = '0;
        if ((state_q == PRESENT) && !C_rdy) begin
            if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                drop  = 1'b1;
                err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
`endif
        slot_free = (state_q == IDLE) || xfer;
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        fifo_pop  = 1'b0;
        if (slot_free) begin
            if (!fifo_empty) begin
                {addr_d, data_d} = fifo_head;
                fifo_pop         = 1'b1;
                state_d          = PRESENT;
            end else if (accept) begin
                addr_d  = H_addr;
                data_d  = H_data;
                state_d = PRESENT;
            end else begin
                state_d = IDLE;
            end
        end else if (drop) begin
            // A dropped request leaves the slot empty for one cycle; the next entry loads on the following edge.
            state_d = IDLE;
        end
        fifo_push = accept && !(slot_free && fifo_empty) && (!fifo_full || fifo_pop);
        case ({accept, xfer || drop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Slot FSM, presented request and registered host-side status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            full_q  <= (count_d == NW'(DEPTH));
            busy_q  <= (count_d != '0);
        end
    end

`ifdef VGA_CFG_TIMEOUT_EN
    // Wait counter and one-cycle drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign Err = err_q;
`else
    // Constant low: no request is ever dropped in this build, TIMEOUT has no effect.
    assign Err = (TIMEOUT < 0);
`endif

    assign C_valid = (state_q == PRESENT);
    assign C_addr  = addr_q;
    assign C_data  = data_q;
    assign H_count = count_q;
    assign H_full  = full_q;
    assign Busy    = busy_q;

endmodule
